// File: rtl/aurora_nfc_ctrl.sv
// Aurora native flow control request generator: turns RX FIFO watermark flags into XOFF/XON requests.
// Optional saturating XOFF/XON transfer counters are built when AURORA_NFC_CTRL_STAT_EN is defined.
module aurora_nfc_ctrl #(
    parameter int PAUSE_W        = 8,
    parameter int XOFF_PAUSE     = 255,
    parameter int REFRESH_CYCLES = 1024
`ifdef AURORA_NFC_CTRL_STAT_EN
    ,
    parameter int STAT_W         = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               channel_up,
    input  logic               fifo_ready,
    input  logic               fifo_below_lwm,
    input  logic               fifo_above_hwm,
    output logic               nfc_tvalid,
    input  logic               nfc_tready,
    output logic [PAUSE_W-1:0] nfc_tdata,
    output logic               xoff_active
`ifdef AURORA_NFC_CTRL_STAT_EN
    ,
    output logic [STAT_W-1:0]  xoff_cnt,
    output logic [STAT_W-1:0]  xon_cnt
`endif
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_VAL = PAUSE_W'(XOFF_PAUSE);

    typedef enum logic [1:0] {
        XON_IDLE,
        SEND_XOFF,
        XOFF_HOLD,
        SEND_XON
    } state_t;

    state_t             state_q, state_d;
    logic               tvalid_q, tvalid_d;
    logic [PAUSE_W-1:0] tdata_q, tdata_d;
    logic               xoff_active_q, xoff_active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    assign accept      = tvalid_q & nfc_tready;
    assign nfc_tvalid  = tvalid_q;
    assign nfc_tdata   = tdata_q;
    assign xoff_active = xoff_active_q;

    always_comb begin
        state_d       = state_q;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        xoff_active_d = xoff_active_q;
        cnt_d         = cnt_q;

        // A dropped link voids the pause, so everything is abandoned without an XON.
        if (!channel_up) begin
            state_d       = XON_IDLE;
            tvalid_d      = 1'b0;
            tdata_d       = '0;
            xoff_active_d = 1'b0;
            cnt_d         = '0;
        end else begin
            case (state_q)
                XON_IDLE: begin
                    if (fifo_ready && fifo_above_hwm && !fifo_below_lwm) begin
                        state_d  = SEND_XOFF;
                        tvalid_d = 1'b1;
                        tdata_d  = PAUSE_VAL;
                    end
                end
                SEND_XOFF: begin
                    if (accept) begin
                        state_d       = XOFF_HOLD;
                        tvalid_d      = 1'b0;
                        tdata_d       = '0;
                        xoff_active_d = 1'b1;
                        cnt_d         = CNT_LOAD;
                    end
                end
                XOFF_HOLD: begin
                    // A FIFO in reset is empty, so it releases the pause like a low watermark.
                    if (fifo_below_lwm || !fifo_ready) begin
                        state_d  = SEND_XON;
                        tvalid_d = 1'b1;
                        tdata_d  = '0;
                        cnt_d    = '0;
                    end else if (cnt_q == '0) begin
                        state_d  = SEND_XOFF;
                        tvalid_d = 1'b1;
                        tdata_d  = PAUSE_VAL;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SEND_XON: begin
                    if (accept) begin
                        state_d       = XON_IDLE;
                        tvalid_d      = 1'b0;
                        tdata_d       = '0;
                        xoff_active_d = 1'b0;
                    end
                end
                default: begin
                    state_d       = XON_IDLE;
                    tvalid_d      = 1'b0;
                    tdata_d       = '0;
                    xoff_active_d = 1'b0;
                    cnt_d         = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= XON_IDLE;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            xoff_active_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            xoff_active_q <= xoff_active_d;
            cnt_q         <= cnt_d;
        end
    end

`ifdef AURORA_NFC_CTRL_STAT_EN
    logic [STAT_W-1:0] xoff_cnt_q, xoff_cnt_d;
    logic [STAT_W-1:0] xon_cnt_q, xon_cnt_d;

    // Counters track accepted transfers only and survive link loss.
    always_comb begin
        xoff_cnt_d = xoff_cnt_q;
        xon_cnt_d  = xon_cnt_q;
        if (accept && state_q == SEND_XOFF && xoff_cnt_q != '1) begin
            xoff_cnt_d = xoff_cnt_q + STAT_W'(1);
        end
        if (accept && state_q == SEND_XON && xon_cnt_q != '1) begin
            xon_cnt_d = xon_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xoff_cnt_q <= '0;
            xon_cnt_q  <= '0;
        end else begin
            xoff_cnt_q <= xoff_cnt_d;
            xon_cnt_q  <= xon_cnt_d;
        end
    end

    assign xoff_cnt = xoff_cnt_q;
    assign xon_cnt  = xon_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_nfc_ctrl.sv
// Directed bench for aurora_nfc_ctrl: expected NFC transfers are queued as stimulus is driven and checked on each handshake.
module tb_aurora_nfc_ctrl;

    localparam int PAUSE_W        = 8;
    localparam int XOFF_PAUSE     = 255;
    localparam int REFRESH_CYCLES = 8;
    localparam int STAT_W         = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               channel_up;
    logic               fifo_ready;
    logic               fifo_below_lwm;
    logic               fifo_above_hwm;
    logic               nfc_tvalid;
    logic               nfc_tready;
    logic [PAUSE_W-1:0] nfc_tdata;
    logic               xoff_active;
`ifdef AURORA_NFC_CTRL_STAT_EN
    logic [STAT_W-1:0]  xoff_cnt;
    logic [STAT_W-1:0]  xon_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    int          xfer_cnt = 0;
    logic [31:0] exp_q[$];

    aurora_nfc_ctrl #(
        .PAUSE_W        (PAUSE_W),
        .XOFF_PAUSE     (XOFF_PAUSE),
        .REFRESH_CYCLES (REFRESH_CYCLES)
`ifdef AURORA_NFC_CTRL_STAT_EN
        ,
        .STAT_W         (STAT_W)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .channel_up     (channel_up),
        .fifo_ready     (fifo_ready),
        .fifo_below_lwm (fifo_below_lwm),
        .fifo_above_hwm (fifo_above_hwm),
        .nfc_tvalid     (nfc_tvalid),
        .nfc_tready     (nfc_tready),
        .nfc_tdata      (nfc_tdata),
        .xoff_active    (xoff_active)
`ifdef AURORA_NFC_CTRL_STAT_EN
        ,
        .xoff_cnt       (xoff_cnt),
        .xon_cnt        (xon_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_output(input string tag, input logic tv, input logic [31:0] td, input logic xa);
        check({tag, "_tvalid"}, 32'(nfc_tvalid), 32'(tv));
        if (tv) check({tag, "_tdata"}, 32'(nfc_tdata), td);
        check({tag, "_xoff_active"}, 32'(xoff_active), 32'(xa));
    endtask

    task automatic apply_stimulus(input logic cu, input logic fr, input logic bl, input logic ah, input logic tr);
        channel_up     = cu;
        fifo_ready     = fr;
        fifo_below_lwm = bl;
        fifo_above_hwm = ah;
        nfc_tready     = tr;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tvalid(input int limit, output int n);
        n = 0;
        while (!nfc_tvalid && n < limit) begin
            step(1);
            n++;
        end
    endtask

    // Handshake seen at the negedge is the one the next posedge will accept.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && nfc_tvalid === 1'b1 && nfc_tready === 1'b1) begin
            xfer_cnt++;
            check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("xfer_tdata", 32'(nfc_tdata), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(2);
        check_output("reset", 1'b0, 0, 1'b0);
        check("reset_tdata", 32'(nfc_tdata), 32'd0);
        rst_n = 1'b1;

        // Basic XOFF followed by XON
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(XOFF_PAUSE);
        step(1);
        check_output("xoff_req", 1'b1, XOFF_PAUSE, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);
        check_output("xoff_acc", 1'b0, 0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(0);
        step(1);
        check_output("xon_req", 1'b1, 0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);
        check_output("xon_acc", 1'b0, 0, 1'b0);
        check("basic_xfers", 32'(xfer_cnt), 32'd2);

        // Backpressure: request must stay frozen until accepted
        base = xfer_cnt;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(XOFF_PAUSE);
        step(1);
        check_output("bp_req", 1'b1, XOFF_PAUSE, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_output("bp_hold", 1'b1, XOFF_PAUSE, 1'b0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);
        check_output("bp_acc", 1'b0, 0, 1'b1);
        check("bp_xfers", 32'(xfer_cnt - base), 32'd1);

        // Refresh: next XOFF raised REFRESH_CYCLES cycles after each accept
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(XOFF_PAUSE);
            wait_tvalid(40, n);
            check("refresh_gap", 32'(n), 32'(REFRESH_CYCLES));
            check_output("refresh_req", 1'b1, XOFF_PAUSE, 1'b1);
            step(1);
            check_output("refresh_acc", 1'b0, 0, 1'b1);
        end
        // Both watermarks set: XON wins, and no XOFF is raised from idle
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        exp_q.push_back(0);
        step(1);
        check_output("both_xon_req", 1'b1, 0, 1'b1);
        step(1);
        check_output("both_xon_acc", 1'b0, 0, 1'b0);
        step(1);
        check_output("both_idle", 1'b0, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);

        // Link loss during a stalled XON
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(XOFF_PAUSE);
        step(1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);
        check_output("ll_xoff_acc", 1'b0, 0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        check_output("ll_xon_req", 1'b1, 0, 1'b1);
        base = xfer_cnt;
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        check_output("ll_drop", 1'b0, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2);
        check_output("ll_idle", 1'b0, 0, 1'b0);
        check("ll_no_xon", 32'(xfer_cnt - base), 32'd0);

        // FIFO reset while paused
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(XOFF_PAUSE);
        step(1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);
        check_output("fr_xoff_acc", 1'b0, 0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(0);
        step(1);
        check_output("fr_xon_req", 1'b1, 0, 1'b1);
        step(1);
        check_output("fr_xon_acc", 1'b0, 0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_output("fr_no_xoff", 1'b0, 0, 1'b0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);

        // Asynchronous reset in the middle of a pending request
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        check_output("ar_req", 1'b1, XOFF_PAUSE, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_output("ar_reset", 1'b0, 0, 1'b0);
        check("ar_reset_tdata", 32'(nfc_tdata), 32'd0);
`ifdef AURORA_NFC_CTRL_STAT_EN
        check("ar_xoff_cnt", 32'(xoff_cnt), 32'd0);
        check("ar_xon_cnt", 32'(xon_cnt), 32'd0);
`endif
        step(1);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Five XOFF/XON rounds; statistics saturate when built in
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            exp_q.push_back(XOFF_PAUSE);
            step(1);
            apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            exp_q.push_back(0);
            step(3);
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            check_output("round_end", 1'b0, 0, 1'b0);
`ifdef AURORA_NFC_CTRL_STAT_EN
            check("stat_xoff_cnt", 32'(xoff_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
            check("stat_xon_cnt", 32'(xon_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
`endif
        end
`ifdef AURORA_NFC_CTRL_STAT_EN
        #2 rst_n = 1'b0;
        #1;
        check("stat_rst_xoff_cnt", 32'(xoff_cnt), 32'd0);
        check("stat_rst_xon_cnt", 32'(xon_cnt), 32'd0);
        step(1);
        rst_n = 1'b1;
`endif
        step(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
